monitor_carga: RTL and testbench
================================

Name: monitor_carga

Overview:
- Downstream consumer of the 5-bit combined battery charge produced by the pack adder stage.
- Samples the total charge on a valid strobe and classifies it into NORMAL / BAJA / CRITICA with hysteresis and N-sample confirmation.
- Drives the alarm, LED-blink and state-change outputs used by the display/indicator stage.

Parameters:
- UMBRAL_BAJA, 10: charge below this is low.
- UMBRAL_CRITICA, 5: charge below this is critical. Must be < UMBRAL_BAJA.
- HISTERESIS, 2: margin added to a threshold before a recovering (upward) transition.
- N_CONFIRM, 4: consecutive agreeing valid samples required to change state. Range 1..15.
- DIV_PARPADEO, 4: blink half-period in clock cycles while in CRITICA. Must be ≥ 1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- carga_total  in  5  combined charge from the adder stage, legal range 0..30
- muestra_valida  in  1  one-cycle strobe: carga_total is sampled this cycle
- estado  out  2  00 = NORMAL, 01 = BAJA, 10 = CRITICA (11 never driven)
- alarma  out  1  1 when estado != NORMAL
- led_alarma  out  1  0 in NORMAL, steady 1 in BAJA, blinking in CRITICA
- cambio  out  1  one-cycle pulse on the cycle after estado changes
- fuera_rango  out  1  one-cycle pulse when a valid sample equals 31
- ultima_carga  out  5  last accepted in-range sample

Behaviour:
- Reset (rst_n = 0 at a rising edge):
  - estado = NORMAL; ultima_carga = 0.
  - Confirm counter = 0; candidate = NORMAL; blink counter = 0.
  - All 1-bit outputs = 0.
  - Reset mid-confirmation discards the partial count.
- Sample acceptance:
  - Only when muestra_valida = 1.
  - carga_total = 31: fuera_rango pulses next cycle. The sample is otherwise ignored (counter, candidate and ultima_carga hold).
  - In-range sample: ultima_carga updates at that edge.
- Candidate zone, computed combinationally from the sample c and the current estado:
  - From NORMAL: c < UMBRAL_CRITICA → CRITICA; else c < UMBRAL_BAJA → BAJA; else NORMAL.
  - From BAJA: c < UMBRAL_CRITICA → CRITICA; else c ≥ UMBRAL_BAJA + HISTERESIS → NORMAL; else BAJA.
  - From CRITICA: c ≥ UMBRAL_BAJA + HISTERESIS → NORMAL; else c ≥ UMBRAL_CRITICA + HISTERESIS → BAJA; else CRITICA.
  - Direct jumps NORMAL↔CRITICA are legal.
- Confirmation, applied on each accepted sample:
  - Candidate == estado: counter ← 0.
  - Candidate != stored candidate: stored candidate ← new candidate; counter ← 1.
  - Otherwise: counter ← counter + 1.
  - When the updated count would reach N_CONFIRM, estado ← candidate at that same edge, counter ← 0, and cambio is asserted for the following cycle.
  - N_CONFIRM = 1 therefore gives a change one edge after the first disagreeing sample.
- Gaps: cycles without muestra_valida hold all state. Samples need not be back-to-back to count as consecutive.
- Blink:
  - The blink counter runs only in CRITICA and is cleared on entry to CRITICA, so led_alarma = 1 on the first CRITICA cycle.
  - led_alarma toggles every DIV_PARPADEO cycles.
  - Leaving CRITICA clears the counter; led_alarma takes the BAJA/NORMAL value immediately.
- Outputs alarma, led_alarma and estado are registered or decoded from registered state only. No combinational path from carga_total.

Optional Feature:
- Macro MONITOR_CARGA_MINMAX_EN.
- Defined:
  - Adds outputs carga_min[4:0] (reset 31) and carga_max[4:0] (reset 0).
  - Both update on every accepted in-range sample.
  - Adds input borrar_minmax, which restores the reset values. If it coincides with a sample, the clear wins.
- Undefined: those ports and registers do not exist. All other behaviour is identical.

Decomposition:
- Shared package (monitor_carga_pkg):
  - estado_t enum: NORMAL = 2'b00, BAJA = 2'b01, CRITICA = 2'b10.
  - CARGA_W = 5 and CARGA_MAX_LEGAL = 30.
- One natural sub-module: monitor_parpadeo. It holds the blink counter and toggle; its inputs are clk, rst_n and enable (estado == CRITICA), and its output is led_blink.
- Classification and confirmation stay in the top module.

Test Plan (default parameters):
- Reset → estado = 00, alarma = 0, led_alarma = 0, ultima_carga = 0, cambio = 0.
- Four valid samples of 8 from NORMAL → estado = 01 after the 4th edge; cambio pulses once; alarma = 1; led_alarma steady 1.
- Samples 8, 8, 20, 8, 8, 8, 8 → no change until the 7th sample: 20 resets the count and the following four 8s are needed.
- In BAJA, samples of 10 and 11 repeated ×6 → stays BAJA (hysteresis). Four samples of 12 → NORMAL.
- Four samples of 3 from NORMAL → CRITICA directly. led_alarma pattern is 1111 0000 1111…, starting on the first CRITICA cycle.
- Sample 31 interleaved within three 3s, followed by one more 3 → fuera_rango pulses; ultima_carga stays 3; CRITICA is reached on the fourth 3.
- Reset asserted after two samples of 3 → count discarded; two more 3s do not change estado.

Source files
------------

// File: rtl/monitor_carga_pkg.sv
// Shared types and widths for the battery-charge monitor (monitor_carga).
package monitor_carga_pkg;

  typedef enum logic [1:0] {
    NORMAL  = 2'b00,
    BAJA    = 2'b01,
    CRITICA = 2'b10
  } estado_t;

  localparam int CARGA_W         = 5;
  localparam int CARGA_MAX_LEGAL = 30;
  localparam int CONF_W          = 4;

endpackage

// File: rtl/monitor_parpadeo.sv
// Blink generator for the CRITICA indication: led_blink is 1 on the first enabled
// cycle and toggles every DIV_PARPADEO cycles; disabling clears the phase.
module monitor_parpadeo #(
  parameter int DIV_PARPADEO = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic led_blink
);

  localparam int CW = (DIV_PARPADEO > 1) ? $clog2(DIV_PARPADEO) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(DIV_PARPADEO - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          fase_q, fase_d;

  always_comb begin
    cnt_d  = '0;
    fase_d = 1'b0;
    if (enable) begin
      if (cnt_q == ULTIMO) begin
        cnt_d  = '0;
        fase_d = ~fase_q;
      end else begin
        cnt_d  = cnt_q + CW'(1);
        fase_d = fase_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      fase_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      fase_q <= fase_d;
    end
  end

  // Phase 0 means lit, so entry into CRITICA shows the LED on immediately.
  assign led_blink = enable & ~fase_q;

endmodule

// File: rtl/monitor_carga.sv
// Battery-charge classifier with hysteresis and N-sample confirmation.
// Optional min/max tracking is enabled with `define MONITOR_CARGA_MINMAX_EN.
module monitor_carga
  import monitor_carga_pkg::*;
#(
  parameter int UMBRAL_BAJA    = 10,
  parameter int UMBRAL_CRITICA = 5,
  parameter int HISTERESIS     = 2,
  parameter int N_CONFIRM      = 4,
  parameter int DIV_PARPADEO   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [4:0]   carga_total,
  input  logic         muestra_valida,
`ifdef MONITOR_CARGA_MINMAX_EN
  input  logic         borrar_minmax,
  output logic [4:0]   carga_min,
  output logic [4:0]   carga_max,
`endif
  output logic [1:0]   estado,
  output logic         alarma,
  output logic         led_alarma,
  output logic         cambio,
  output logic         fuera_rango,
  output logic [4:0]   ultima_carga
);

  localparam logic [CARGA_W-1:0] LIM_BAJA      = CARGA_W'(UMBRAL_BAJA);
  localparam logic [CARGA_W-1:0] LIM_CRIT      = CARGA_W'(UMBRAL_CRITICA);
  localparam logic [CARGA_W-1:0] LIM_BAJA_REC  = CARGA_W'(UMBRAL_BAJA + HISTERESIS);
  localparam logic [CARGA_W-1:0] LIM_CRIT_REC  = CARGA_W'(UMBRAL_CRITICA + HISTERESIS);
  localparam logic [CARGA_W-1:0] MAX_LEGAL     = CARGA_W'(CARGA_MAX_LEGAL);
  localparam logic [CONF_W-1:0]  N_OBJETIVO    = CONF_W'(N_CONFIRM);

  estado_t              estado_q, estado_d;
  estado_t              cand_q, cand_d;
  estado_t              cand_zona;
  logic [CONF_W-1:0]    cnt_q, cnt_d, cnt_nuevo;
  logic [CARGA_W-1:0]   ultima_q, ultima_d;
  logic                 cambio_q, cambio_d;
  logic                 fuera_q, fuera_d;
  logic                 muestra_fuera;
  logic                 acepta;
  logic                 led_blink;

  // muestra_valida is a one-cycle strobe with no back-pressure: carga_total is
  // consumed on every rising edge where it is high, there is no ready.
  assign muestra_fuera = carga_total > MAX_LEGAL;
  assign acepta        = muestra_valida && !muestra_fuera;

  // Recovering transitions need the threshold plus the hysteresis margin.
  always_comb begin
    cand_zona = estado_q;
    case (estado_q)
      NORMAL: begin
        if (carga_total < LIM_CRIT)      cand_zona = CRITICA;
        else if (carga_total < LIM_BAJA) cand_zona = BAJA;
        else                             cand_zona = NORMAL;
      end
      BAJA: begin
        if (carga_total < LIM_CRIT)           cand_zona = CRITICA;
        else if (carga_total >= LIM_BAJA_REC) cand_zona = NORMAL;
        else                                  cand_zona = BAJA;
      end
      CRITICA: begin
        if (carga_total >= LIM_BAJA_REC)      cand_zona = NORMAL;
        else if (carga_total >= LIM_CRIT_REC) cand_zona = BAJA;
        else                                  cand_zona = CRITICA;
      end
      default: cand_zona = NORMAL;
    endcase
  end

  always_comb begin
    estado_d  = estado_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    cnt_nuevo = cnt_q;
    ultima_d  = ultima_q;
    cambio_d  = 1'b0;
    fuera_d   = 1'b0;
    if (muestra_valida && muestra_fuera) begin
      fuera_d = 1'b1;
    end else if (acepta) begin
      ultima_d = carga_total;
      if (cand_zona == estado_q) begin
        cnt_d = '0;
      end else begin
        if (cand_zona != cand_q) begin
          cand_d    = cand_zona;
          cnt_nuevo = CONF_W'(1);
        end else begin
          cnt_nuevo = cnt_q + CONF_W'(1);
        end
        if (cnt_nuevo == N_OBJETIVO) begin
          estado_d = cand_zona;
          cnt_d    = '0;
          cambio_d = 1'b1;
        end else begin
          cnt_d = cnt_nuevo;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado_q <= NORMAL;
      cand_q   <= NORMAL;
      cnt_q    <= '0;
      ultima_q <= '0;
      cambio_q <= 1'b0;
      fuera_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      ultima_q <= ultima_d;
      cambio_q <= cambio_d;
      fuera_q  <= fuera_d;
    end
  end

  monitor_parpadeo #(
    .DIV_PARPADEO (DIV_PARPADEO)
  ) u_parpadeo (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (estado_q == CRITICA),
    .led_blink (led_blink)
  );

  always_comb begin
    led_alarma = 1'b0;
    case (estado_q)
      BAJA:    led_alarma = 1'b1;
      CRITICA: led_alarma = led_blink;
      default: led_alarma = 1'b0;
    endcase
  end

  assign estado       = estado_q;
  assign alarma       = (estado_q != NORMAL);
  assign cambio       = cambio_q;
  assign fuera_rango  = fuera_q;
  assign ultima_carga = ultima_q;

`ifdef MONITOR_CARGA_MINMAX_EN
  logic [CARGA_W-1:0] min_q, min_d;
  logic [CARGA_W-1:0] max_q, max_d;

  // A clear request overrides a coincident sample.
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (borrar_minmax) begin
      min_d = '1;
      max_d = '0;
    end else if (acepta) begin
      if (carga_total < min_q) min_d = carga_total;
      if (carga_total > max_q) max_d = carga_total;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign carga_min = min_q;
  assign carga_max = max_q;
`endif

endmodule

// File: tb/tb_monitor_carga.sv
// Directed bench for monitor_carga: reference model from the classification rules,
// per-cycle comparison on the falling edge, plus literal checkpoints.
module tb_monitor_carga;

  localparam int UB  = 10;
  localparam int UC  = 5;
  localparam int HI  = 2;
  localparam int NC  = 4;
  localparam int DIV = 4;

  logic       clk;
  logic       rst_n;
  logic [4:0] carga_total;
  logic       muestra_valida;
  logic [1:0] estado;
  logic       alarma;
  logic       led_alarma;
  logic       cambio;
  logic       fuera_rango;
  logic [4:0] ultima_carga;
`ifdef MONITOR_CARGA_MINMAX_EN
  logic       borrar_minmax;
  logic [4:0] carga_min;
  logic [4:0] carga_max;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  monitor_carga #(
    .UMBRAL_BAJA    (UB),
    .UMBRAL_CRITICA (UC),
    .HISTERESIS     (HI),
    .N_CONFIRM      (NC),
    .DIV_PARPADEO   (DIV)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .carga_total    (carga_total),
    .muestra_valida (muestra_valida),
`ifdef MONITOR_CARGA_MINMAX_EN
    .borrar_minmax  (borrar_minmax),
    .carga_min      (carga_min),
    .carga_max      (carga_max),
`endif
    .estado         (estado),
    .alarma         (alarma),
    .led_alarma     (led_alarma),
    .cambio         (cambio),
    .fuera_rango    (fuera_rango),
    .ultima_carga   (ultima_carga)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  // Reference model: zones 0=NORMAL 1=BAJA 2=CRITICA
  int m_estado = 0, m_run_zone = 0, m_run_len = 0, m_ultima = 0;
  int m_cambio = 0, m_fuera = 0, m_crit_cycles = 0;

  function automatic int zona(input int c, input int e);
    if (e == 0) return (c < UC) ? 2 : ((c < UB) ? 1 : 0);
    if (e == 1) return (c < UC) ? 2 : ((c >= UB + HI) ? 0 : 1);
    return (c >= UB + HI) ? 0 : ((c >= UC + HI) ? 1 : 2);
  endfunction

  initial begin
    int prev, z, c;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_estado = 0; m_run_zone = 0; m_run_len = 0; m_ultima = 0;
        m_cambio = 0; m_fuera = 0; m_crit_cycles = 0;
      end else begin
        prev     = m_estado;
        m_cambio = 0;
        m_fuera  = 0;
        if (muestra_valida) begin
          c = int'(carga_total);
          if (c == 31) begin
            m_fuera = 1;
          end else begin
            m_ultima = c;
            z = zona(c, m_estado);
            if (z == m_estado) m_run_len = 0;
            else begin
              if (z != m_run_zone) begin m_run_zone = z; m_run_len = 1; end
              else m_run_len++;
              if (m_run_len == NC) begin m_estado = z; m_run_len = 0; m_cambio = 1; end
            end
          end
        end
        if (m_estado == 2) m_crit_cycles = (prev == 2) ? m_crit_cycles + 1 : 0;
        else m_crit_cycles = 0;
      end
    end
  end

  function automatic int exp_led();
    if (m_estado == 0) return 0;
    if (m_estado == 1) return 1;
    return ((m_crit_cycles / DIV) % 2 == 0) ? 1 : 0;
  endfunction

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("m_estado", estado, m_estado);
        check("m_alarma", alarma, (m_estado != 0) ? 1 : 0);
        check("m_led", led_alarma, exp_led());
        check("m_cambio", cambio, m_cambio);
        check("m_fuera", fuera_rango, m_fuera);
        check("m_ultima", ultima_carga, m_ultima);
      end
    end
  end

  // Driver tasks: inputs change 2 time units after a rising edge
  task automatic send(input int c);
    muestra_valida = 1'b1;
    carga_total    = 5'(c);
    @(posedge clk); #2;
    muestra_valida = 1'b0;
  endtask

  task automatic send_n(input int c, input int n);
    for (int i = 0; i < n; i++) send(c);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  initial begin
    rst_n = 1'b0; muestra_valida = 1'b0; carga_total = 5'd0;
`ifdef MONITOR_CARGA_MINMAX_EN
    borrar_minmax = 1'b0;
`endif
    idle(2);
    rst_n  = 1'b1;
    chk_en = 1;
    check("rst_estado", estado, 0);
    check("rst_alarma", alarma, 0);
    check("rst_led", led_alarma, 0);
    check("rst_ultima", ultima_carga, 0);
    check("rst_cambio", cambio, 0);
    check("rst_fuera", fuera_rango, 0);

    // Four 8s with gaps in between -> BAJA
    send(8); idle(3); send(8); idle(2); send(8);
    check("baja_pre", estado, 0);
    send(8);
    check("baja_estado", estado, 1);
    check("baja_cambio", cambio, 1);
    check("baja_alarma", alarma, 1);
    check("baja_led", led_alarma, 1);
    check("baja_ultima", ultima_carga, 8);
    idle(1);
    check("baja_cambio_off", cambio, 0);

    // Back to NORMAL, then a 20 interrupts the run
    send_n(12, 4);
    check("normal_back", estado, 0);
    send(8); send(8); send(20); send_n(8, 3);
    check("run_reset_hold", estado, 0);
    send(8);
    check("run_reset_change", estado, 1);

    // Hysteresis band keeps BAJA
    for (int i = 0; i < 6; i++) begin send(10); send(11); end
    check("hyst_hold", estado, 1);
    send_n(12, 3);
    check("hyst_pre", estado, 1);
    send(12);
    check("hyst_normal", estado, 0);

    // NORMAL straight to CRITICA, blink 1111 0000
    send_n(3, 4);
    check("crit_direct", estado, 2);
    for (int k = 0; k < 10; k++) begin
      check("blink", led_alarma, ((k % 8) < 4) ? 1 : 0);
      idle(1);
    end

    // Out-of-range sample interleaved
    send_n(12, 4);
    check("crit_recover", estado, 0);
    send(3); send(31);
    check("fuera_pulse", fuera_rango, 1);
    check("fuera_ultima", ultima_carga, 3);
    send(3);
    check("fuera_off", fuera_rango, 0);
    send(3);
    check("fuera_hold", estado, 0);
    send(3);
    check("fuera_crit", estado, 2);

    // Reset mid-confirmation
    send_n(12, 4);
    send(3); send(3);
    rst_n = 1'b0; idle(1); rst_n = 1'b1;
    check("midrst_ultima", ultima_carga, 0);
    send(3); send(3);
    check("midrst_hold", estado, 0);

    // Threshold boundaries
    send(9); send(5); send(9); send(5);
    check("bnd_baja", estado, 1);
    send_n(7, 4);
    check("bnd_baja_hold", estado, 1);
    send_n(4, 4);
    check("bnd_crit", estado, 2);
    send_n(6, 4);
    check("bnd_crit_hold", estado, 2);
    send_n(7, 4);
    check("bnd_crit_baja", estado, 1);
    send_n(30, 4);
    check("bnd_max", estado, 0);
    check("bnd_max_ultima", ultima_carga, 30);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
